// File: rtl/regfile_dump_if.sv
// Word stream from the register-file dumper to its consumer.
// A word transfers on a rising clk edge where dump_valid && dump_ready. While dump_valid
// is high, dump_idx and dump_data hold steady until that transfer. dump_valid does not
// depend on dump_ready.
interface regfile_dump_if;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  modport master (output dump_valid, output dump_idx, output dump_data, input dump_ready);
  modport slave  (input dump_valid, input dump_idx, input dump_data, output dump_ready);
endinterface

// File: rtl/regfile_dump.sv
// Walks a (possibly wrapping) index range of a 32-entry register file and streams each
// register out as an (index, data) word, folding accepted words into an XOR checksum.
module regfile_dump #(
  parameter bit SKIP_X0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       first_idx,
  input  logic [4:0]       last_idx,
  output logic [4:0]       ra,
  input  logic [31:0]      rd,
  regfile_dump_if.master   dump,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  last_q, last_d;
  logic        valid_q, valid_d;
  logic [4:0]  didx_q, didx_d;
  logic [31:0] ddata_q, ddata_d;
  logic [31:0] csum_q, csum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      didx_q  <= '0;
      ddata_q <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      didx_q  <= didx_d;
      ddata_q <= ddata_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    didx_d  = didx_q;
    ddata_d = ddata_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = first_idx;
          last_d  = last_idx;
          csum_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Skipped x0 still consumes its slot in the range, so wrap/termination is unchanged.
        if (SKIP_X0 && (idx_q == 5'd0)) begin
          if (idx_q == last_q) state_d = DONE;
          else                 idx_d   = idx_q + 5'd1;
        end else begin
          ddata_d = rd;
          didx_d  = idx_q;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (valid_q && dump.dump_ready) begin
          csum_d  = csum_q ^ ddata_q;
          valid_d = 1'b0;
          if (idx_q == last_q) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = LOAD;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The read port is only addressed while a word is being captured.
  assign ra             = (state_q == LOAD) ? idx_q : 5'd0;
  assign dump.dump_valid = valid_q;
  assign dump.dump_idx   = didx_q;
  assign dump.dump_data  = ddata_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign checksum       = csum_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: u0 streams every index, u1 skips x0.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [4:0]  first_idx, last_idx;
  logic [4:0]  ra0, ra1;
  logic [31:0] rd0, rd1;
  logic        busy0, busy1, done0, done1;
  logic [31:0] csum0, csum1;
  logic [1:0]  st0, st1;
  logic [31:0] rf [32];

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] obs_q[$];
  int hs_cyc_q[$];
  int done_cnt, done_cyc, zero_valid_cnt;

  always #5 clk = ~clk;

  regfile_dump_if if0();
  regfile_dump_if if1();

  assign rd0 = rf[ra0];
  assign rd1 = rf[ra1];

  regfile_dump #(.SKIP_X0(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .first_idx(first_idx), .last_idx(last_idx),
    .ra(ra0), .rd(rd0), .dump(if0), .busy(busy0), .done(done0), .checksum(csum0),
    .dbg_state(st0)
  );

  regfile_dump #(.SKIP_X0(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .first_idx(first_idx), .last_idx(last_idx),
    .ra(ra1), .rd(rd1), .dump(if1), .busy(busy1), .done(done1), .checksum(csum1),
    .dbg_state(st1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs;
    obs_q.delete();
    hs_cyc_q.delete();
    done_cnt       = 0;
    done_cyc       = -1;
    zero_valid_cnt = 0;
  endtask

  // Records words that will transfer at the coming edge, plus done pulses.
  task automatic collect(input bit sel, input int ncyc, input int base);
    for (int c = 0; c < ncyc; c++) begin
      logic v, r, d;
      logic [4:0] ix;
      logic [31:0] dt;
      v  = sel ? if1.dump_valid : if0.dump_valid;
      r  = sel ? if1.dump_ready : if0.dump_ready;
      d  = sel ? done1 : done0;
      ix = sel ? if1.dump_idx : if0.dump_idx;
      dt = sel ? if1.dump_data : if0.dump_data;
      if (v && r) begin
        obs_q.push_back({ix, dt});
        hs_cyc_q.push_back(base + c);
      end
      if (v && (ix == 5'd0)) zero_valid_cnt++;
      if (d) begin
        done_cnt++;
        done_cyc = base + c;
      end
      tick();
    end
  endtask

  task automatic start_dump(input bit sel, input logic [4:0] f, input logic [4:0] l);
    first_idx = f;
    last_idx  = l;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_tests++;
    if ({ra0, if0.dump_valid, if0.dump_idx, if0.dump_data, busy0, done0, csum0, st0} !== '0) begin
      n_fail++;
      $display("FAIL reset_u0: got ra=%0d v=%b idx=%0d data=%h busy=%b done=%b csum=%h st=%0d, expected all 0",
               ra0, if0.dump_valid, if0.dump_idx, if0.dump_data, busy0, done0, csum0, st0);
    end
    n_tests++;
    if ({ra1, if1.dump_valid, if1.dump_idx, if1.dump_data, busy1, done1, csum1, st1} !== '0) begin
      n_fail++;
      $display("FAIL reset_u1: got ra=%0d v=%b busy=%b done=%b csum=%h, expected all 0",
               ra1, if1.dump_valid, busy1, done1, csum1);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_range;
    logic [36:0] exp_q[$];
    exp_q.push_back({5'd5, 32'd6});
    exp_q.push_back({5'd6, 32'd0});
    exp_q.push_back({5'd7, 32'd0});
    exp_q.push_back({5'd8, 32'd0});
    exp_q.push_back({5'd9, 32'h2004});
    if0.dump_ready = 1'b1;
    start_dump(1'b0, 5'd5, 5'd9);
    n_tests++;
    if ({busy0, if0.dump_valid, ra0} !== {1'b1, 1'b0, 5'd5}) begin
      n_fail++;
      $display("FAIL range_load: got busy=%b v=%b ra=%0d, expected busy=1 v=0 ra=5", busy0, if0.dump_valid, ra0);
    end
    tick();
    n_tests++;
    if ({if0.dump_valid, if0.dump_idx, if0.dump_data, ra0} !== {1'b1, 5'd5, 32'd6, 5'd0}) begin
      n_fail++;
      $display("FAIL range_first_word: got v=%b idx=%0d data=%h ra=%0d, expected v=1 idx=5 data=6 ra=0",
               if0.dump_valid, if0.dump_idx, if0.dump_data, ra0);
    end
    clear_obs();
    collect(1'b0, 30, 0);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL range_count: got %0d words, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL range_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h",
                 i, obs_q[i][36:32], obs_q[i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
    for (int i = 1; i < hs_cyc_q.size(); i++) begin
      n_tests++;
      if (hs_cyc_q[i] - hs_cyc_q[i-1] != 2) begin
        n_fail++;
        $display("FAIL range_rate%0d: got spacing %0d cycles, expected 2", i, hs_cyc_q[i] - hs_cyc_q[i-1]);
      end
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL range_done_count: got %0d, expected 1", done_cnt);
    end
    if (hs_cyc_q.size() > 0) begin
      n_tests++;
      if (done_cyc != hs_cyc_q[hs_cyc_q.size()-1] + 1) begin
        n_fail++;
        $display("FAIL range_done_timing: got cycle %0d, expected %0d", done_cyc, hs_cyc_q[hs_cyc_q.size()-1] + 1);
      end
    end
    n_tests++;
    if ({csum0, busy0, ra0} !== {32'h2002, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL range_checksum: got csum=%h busy=%b ra=%0d, expected csum=00002002 busy=0 ra=0", csum0, busy0, ra0);
    end
  endtask

  task automatic test_stall;
    if0.dump_ready = 1'b0;
    start_dump(1'b0, 5'd9, 5'd9);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rf[9] = 32'hffff_ffff;
      #1;
      n_tests++;
      if ({if0.dump_valid, if0.dump_idx, if0.dump_data} !== {1'b1, 5'd9, 32'h2004}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b idx=%0d data=%h, expected v=1 idx=9 data=00002004",
                 i, if0.dump_valid, if0.dump_idx, if0.dump_data);
      end
      tick();
    end
    if0.dump_ready = 1'b1;
    tick();
    n_tests++;
    if ({done0, if0.dump_valid, csum0} !== {1'b1, 1'b0, 32'h2004}) begin
      n_fail++;
      $display("FAIL stall_release: got done=%b v=%b csum=%h, expected done=1 v=0 csum=00002004",
               done0, if0.dump_valid, csum0);
    end
    tick();
    n_tests++;
    if ({done0, busy0} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_idle: got done=%b busy=%b, expected 0 0", done0, busy0);
    end
    rf[9] = 32'h2004;
  endtask

  task automatic test_async_reset;
    if0.dump_ready = 1'b0;
    start_dump(1'b0, 5'd5, 5'd9);
    tick();
    tick();
    n_tests++;
    if (if0.dump_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%b, expected 1", if0.dump_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({if0.dump_valid, if0.dump_idx, if0.dump_data, busy0, done0, csum0, ra0} !== '0) begin
      n_fail++;
      $display("FAIL areset_now: got v=%b idx=%0d data=%h busy=%b done=%b csum=%h ra=%0d, expected all 0",
               if0.dump_valid, if0.dump_idx, if0.dump_data, busy0, done0, csum0, ra0);
    end
    tick();
    rst = 1'b0;
    if0.dump_ready = 1'b1;
    clear_obs();
    collect(1'b0, 4, 0);
    n_tests++;
    if ({done_cnt, obs_q.size()} != {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL areset_quiet: got done=%0d words=%0d, expected 0 0", done_cnt, obs_q.size());
    end
    start_dump(1'b0, 5'd5, 5'd5);
    clear_obs();
    collect(1'b0, 10, 0);
    n_tests++;
    if (obs_q.size() != 1 || obs_q[0] !== {5'd5, 32'd6} || done_cnt != 1 || csum0 !== 32'd6) begin
      n_fail++;
      $display("FAIL areset_restart: got words=%0d done=%0d csum=%h, expected one word (5,6) done=1 csum=6",
               obs_q.size(), done_cnt, csum0);
    end
  endtask

  task automatic test_busy_ignored;
    if0.dump_ready = 1'b1;
    start_dump(1'b0, 5'd5, 5'd6);
    clear_obs();
    collect(1'b0, 1, 0);
    first_idx = 5'd9;
    last_idx  = 5'd9;
    start0    = 1'b1;
    collect(1'b0, 1, 1);
    start0 = 1'b0;
    collect(1'b0, 20, 2);
    n_tests++;
    if (obs_q.size() != 2 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_count: got words=%0d done=%0d, expected 2 1", obs_q.size(), done_cnt);
    end else begin
      n_tests++;
      if ({obs_q[0], obs_q[1], csum0} !== {5'd5, 32'd6, 5'd6, 32'd0, 32'd6}) begin
        n_fail++;
        $display("FAIL busy_words: got (%0d,%h) (%0d,%h) csum=%h, expected (5,6) (6,0) csum=6",
                 obs_q[0][36:32], obs_q[0][31:0], obs_q[1][36:32], obs_q[1][31:0], csum0);
      end
    end
  endtask

  task automatic test_wrap(input bit sel);
    logic [36:0] exp_q[$];
    logic [31:0] exp_csum;
    exp_q.push_back({5'd30, 32'h30});
    exp_q.push_back({5'd31, 32'h31});
    if (!sel) exp_q.push_back({5'd0, 32'hdead});
    exp_q.push_back({5'd1, 32'h11});
    exp_csum = sel ? 32'h10 : 32'hdebd;
    if0.dump_ready = 1'b1;
    if1.dump_ready = 1'b1;
    start_dump(sel, 5'd30, 5'd1);
    clear_obs();
    collect(sel, 20, 0);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap%0d_count: got %0d words, expected %0d", sel, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap%0d_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h",
                 sel, i, obs_q[i][36:32], obs_q[i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
    n_tests++;
    if ({done_cnt, (sel ? csum1 : csum0)} !== {32'd1, exp_csum}) begin
      n_fail++;
      $display("FAIL wrap%0d_end: got done=%0d csum=%h, expected done=1 csum=%h",
               sel, done_cnt, sel ? csum1 : csum0, exp_csum);
    end
    if (sel) begin
      n_tests++;
      if (zero_valid_cnt != 0) begin
        n_fail++;
        $display("FAIL wrap1_x0_valid: got %0d cycles with idx 0 valid, expected 0", zero_valid_cnt);
      end
    end
  endtask

  task automatic test_skip_zero;
    if1.dump_ready = 1'b1;
    start_dump(1'b1, 5'd0, 5'd0);
    n_tests++;
    if ({done1, busy1, if1.dump_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL skip0_load: got done=%b busy=%b v=%b, expected 0 1 0", done1, busy1, if1.dump_valid);
    end
    tick();
    n_tests++;
    if ({done1, if1.dump_valid, csum1} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL skip0_done: got done=%b v=%b csum=%h, expected done=1 v=0 csum=0", done1, if1.dump_valid, csum1);
    end
    tick();
    n_tests++;
    if ({done1, busy1, if1.dump_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL skip0_idle: got done=%b busy=%b v=%b, expected 0 0 0", done1, busy1, if1.dump_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[5] = 32'd6;
    rf[9] = 32'h2004;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    first_idx = 5'd0;
    last_idx  = 5'd0;
    if0.dump_ready = 1'b1;
    if1.dump_ready = 1'b1;

    test_reset();
    test_range();
    test_stall();
    test_async_reset();
    test_busy_ignored();
    rf[30] = 32'h30;
    rf[31] = 32'h31;
    rf[0]  = 32'hdead;
    rf[1]  = 32'h11;
    test_wrap(1'b1);
    test_wrap(1'b0);
    test_skip_zero();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
